fp16_add_seq: RTL



---
 rtl/fp16_add_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fp16_add_seq.sv
// Multi-cycle FP16 adder: one align shift / normalize shift per cycle, truncating, denormals flushed.
// Optional FP16_ADD_SPECIALS_EN: inf/NaN operands bypass the datapath and resolve at acceptance.
module fp16_add_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        sign_q, sign_d;
  logic        sub_q, sub_d;
  logic [5:0]  exp_q, exp_d;
  logic [10:0] mb_q, mb_d;
  logic [10:0] ms_q, ms_d;
  logic [3:0]  diff_q, diff_d;
  logic [11:0] sum_q, sum_d;
  logic [15:0] res_q, res_d;

  logic [4:0]  ea, eb, e_big, e_small, dexp;
  logic [10:0] ma, mb, m_big, m_small;
  logic        a_big;
  logic [5:0]  exp_inc, exp_dec;

  always_comb begin
    ea      = a[14:10];
    eb      = b[14:10];
    ma      = (ea == 5'd0) ? 11'd0 : {1'b1, a[9:0]};
    mb      = (eb == 5'd0) ? 11'd0 : {1'b1, b[9:0]};
    a_big   = {ea, ma} >= {eb, mb};
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    m_big   = a_big ? ma : mb;
    m_small = a_big ? mb : ma;
    dexp    = e_big - e_small;
    exp_inc = exp_q + 6'd1;
    exp_dec = exp_q - 6'd1;
  end

`ifdef FP16_ADD_SPECIALS_EN
  logic        a_inf, b_inf, a_nan, b_nan, spec_hit;
  logic [15:0] spec_res;
  always_comb begin
    a_nan    = (ea == 5'h1F) && (a[9:0] != 10'd0);
    b_nan    = (eb == 5'h1F) && (b[9:0] != 10'd0);
    a_inf    = (ea == 5'h1F) && (a[9:0] == 10'd0);
    b_inf    = (eb == 5'h1F) && (b[9:0] == 10'd0);
    spec_hit = (ea == 5'h1F) || (eb == 5'h1F);
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15])))
      spec_res = 16'h7E00;
    else if (a_inf)
      spec_res = {a[15], 15'h7C00};
    else
      spec_res = {b[15], 15'h7C00};
  end
`endif

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    mb_d    = mb_q;
    ms_d    = ms_q;
    diff_d  = diff_q;
    sum_d   = sum_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = a_big ? a[15] : b[15];
          sub_d   = a[15] ^ b[15];
          exp_d   = {1'b0, e_big};
          mb_d    = m_big;
          state_d = ALIGN;
          // Beyond 11 positions every small-mantissa bit would be shifted out anyway
          if (dexp > 5'd11) begin
            ms_d   = 11'd0;
            diff_d = 4'd0;
          end else begin
            ms_d   = m_small;
            diff_d = dexp[3:0];
          end
`ifdef FP16_ADD_SPECIALS_EN
          if (spec_hit) begin
            res_d   = spec_res;
            state_d = DONE;
          end
`endif
        end
      end
      ALIGN: begin
        if (diff_q == 4'd0) begin
          state_d = ADD;
        end else begin
          ms_d   = ms_q >> 1;
          diff_d = diff_q - 4'd1;
        end
      end
      ADD: begin
        sum_d   = sub_q ? ({1'b0, mb_q} - {1'b0, ms_q}) : ({1'b0, mb_q} + {1'b0, ms_q});
        state_d = NORM;
      end
      NORM: begin
        if (sum_q[11]) begin
          sum_d   = sum_q >> 1;
          exp_d   = exp_inc;
          res_d   = (exp_inc >= 6'd31) ? {sign_q, 15'h7C00} : {sign_q, exp_inc[4:0], sum_q[10:1]};
          state_d = DONE;
        end else if (sum_q == 12'd0) begin
          res_d   = 16'h0000;
          state_d = DONE;
        end else if (sum_q[10]) begin
          res_d   = {sign_q, exp_q[4:0], sum_q[9:0]};
          state_d = DONE;
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_dec;
          if (exp_dec == 6'd0) begin
            res_d   = 16'h0000;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= 6'd0;
      mb_q    <= 11'd0;
      ms_q    <= 11'd0;
      diff_q  <= 4'd0;
      sum_q   <= 12'd0;
      res_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      mb_q    <= mb_d;
      ms_q    <= ms_d;
      diff_q  <= diff_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
endmodule
